ps2_scancode_rx: RTL and testbench

Serial PS/2 keyboard receiver that turns the raw `ps2_clk`/`ps2_data` line pair into one-cycle key events on the `key_strobe`/`key_pressed`/`key_extended`/`key_code` interface. That interface is what the Oric keyboard matrix consumes. It sits between the board PS/2 pins (or the MiST IO controller's PS/2 emulation) and the matrix block, in the `clk_sys` domain. It handles the E0 and F0 prefixes, so each strobe carries one complete make or break event.

---
 rtl/ps2_scancode_rx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and filters the line pair, deframes
// 11-bit frames and folds E0/F0 prefixes into single make/break key events.
module ps2_scancode_rx #(
  parameter int unsigned FILT    = 8,
  parameter int unsigned TIMEOUT = 24000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q;
  logic [7:0]    fcnt_q;
  logic          fall, fall_q, fbit_q;
  logic          tmo;

  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          bvld_q, bvld_d, ferr_q, ferr_d;
  logic [7:0]    byte_q, byte_d;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic          strobe_q, strobe_d, pressed_q, pressed_d, extd_q, extd_d, err_q, err_d;
  logic [7:0]    code_q, code_d;

  // A level change is accepted on the FILT-th consecutive differing sample.
  assign fall = filt_q && !clk_s2_q && (fcnt_q == 8'(FILT - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      fall_q   <= 1'b0;
      fbit_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      fall_q   <= fall;
      if (fall) fbit_q <= dat_s2_q;
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == 8'(FILT - 1)) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  // Counter is cleared as the edge is accepted; the -2 lines the abort up with
  // the two register stages between the edge and the frame_err output.
  assign tmo = (state_q != IDLE) && (tcnt_q == TW'(TIMEOUT - 2));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    byte_d  = byte_q;
    bvld_d  = 1'b0;
    ferr_d  = 1'b0;
    tcnt_d  = (fall || state_q == IDLE) ? '0 : tcnt_q + TW'(1);
    if (tmo) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!fbit_q) begin
            state_d = DATA;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          shreg_d = {fbit_q, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = fbit_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if ((^{shreg_q, par_q}) && fbit_q) begin
            bvld_d = 1'b1;
            byte_d = shreg_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    code_d    = code_q;
    pressed_d = pressed_q;
    extd_d    = extd_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    if (ferr_q) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (bvld_q) begin
      case (byte_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          code_d    = byte_q;
          pressed_d = ~brk_q;
          extd_d    = ext_q;
          strobe_d  = 1'b1;
          ext_d     = 1'b0;
          brk_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tcnt_q    <= '0;
      bvld_q    <= 1'b0;
      ferr_q    <= 1'b0;
      byte_q    <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      strobe_q  <= 1'b0;
      pressed_q <= 1'b0;
      extd_q    <= 1'b0;
      code_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tcnt_q    <= tcnt_d;
      bvld_q    <= bvld_d;
      ferr_q    <= ferr_d;
      byte_q    <= byte_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      strobe_q  <= strobe_d;
      pressed_q <= pressed_d;
      extd_q    <= extd_d;
      code_q    <= code_d;
      err_q     <= err_d;
    end
  end

  assign key_strobe   = strobe_q;
  assign key_pressed  = pressed_q;
  assign key_extended = extd_q;
  assign key_code     = code_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: table of frames with expected events,
// plus hand sequences for timeout, glitch rejection and mid-frame reset.
module tb_ps2_scancode_rx;

  localparam int FILT    = 4;
  localparam int TIMEOUT = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_strobe, key_pressed, key_extended, frame_err;
  logic [7:0] key_code;

  ps2_scancode_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys      (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_strobe   (key_strobe),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .key_code     (key_code),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } evt_t;

  evt_t evq[$];
  int   both_cnt = 0;

  always @(negedge clk) begin
    if (key_strobe && frame_err) both_cnt++;
    if (key_strobe)     evq.push_back('{cyc, 1'b0, key_code, key_pressed, key_extended});
    else if (frame_err) evq.push_back('{cyc, 1'b1, key_code, key_pressed, key_extended});
  end

  // bad: 0 = good frame, 1 = flipped parity, 2 = stop bit 0
  typedef struct {
    logic [7:0] b;
    logic [1:0] bad;
    bit         exp_s;
    bit         exp_e;
    logic [7:0] code;
    bit         pr;
    bit         ex;
  } vec_t;

  localparam int NV = 30;
  vec_t tv [NV];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output int c0);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    c0 = cyc;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [1:0] bad, output int c0);
    int c;
    logic [7:0] bv;
    bv = b;
    send_bit(1'b0, c);
    for (int i = 0; i < 8; i++) send_bit(bv[i], c);
    send_bit((~^bv) ^ (bad == 2'd1), c);
    send_bit(bad != 2'd2, c0);
    ps2_data = 1'b1;
  endtask

  task automatic check_events(input string name, input bit exp_s, input bit exp_e,
                              input logic [7:0] code, input bit pr, input bit ex,
                              input int exp_cyc);
    int n_exp;
    n_exp = (exp_s || exp_e) ? 1 : 0;
    chk({name, " count"}, evq.size(), n_exp);
    if (n_exp == 1 && evq.size() == 1) begin
      chk({name, " cycle"}, evq[0].cyc, exp_cyc);
      chk({name, " is_err"}, evq[0].is_err, exp_e);
      if (exp_s) begin
        chk({name, " code"}, evq[0].code, code);
        chk({name, " pressed"}, evq[0].pressed, pr);
        chk({name, " extended"}, evq[0].ext, ex);
      end
    end
    evq.delete();
  endtask

  initial begin
    int c0;
    int c;
    logic [7:0] b45;

    tv[0]  = '{8'h1C, 2'd0, 1, 0, 8'h1C, 1, 0};
    tv[1]  = '{8'hE0, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[2]  = '{8'hF0, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[3]  = '{8'h75, 2'd0, 1, 0, 8'h75, 0, 1};
    tv[4]  = '{8'h75, 2'd0, 1, 0, 8'h75, 1, 0};
    tv[5]  = '{8'h1C, 2'd1, 0, 1, 8'h00, 0, 0};
    tv[6]  = '{8'h1C, 2'd0, 1, 0, 8'h1C, 1, 0};
    tv[7]  = '{8'hF0, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[8]  = '{8'h1C, 2'd1, 0, 1, 8'h00, 0, 0};
    tv[9]  = '{8'h12, 2'd0, 1, 0, 8'h12, 1, 0};
    tv[10] = '{8'hF0, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[11] = '{8'hE0, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[12] = '{8'hF0, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[13] = '{8'h6B, 2'd0, 1, 0, 8'h6B, 0, 1};
    tv[14] = '{8'hE0, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[15] = '{8'hAA, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[16] = '{8'h1C, 2'd0, 1, 0, 8'h1C, 1, 0};
    tv[17] = '{8'hF0, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[18] = '{8'hFA, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[19] = '{8'h00, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[20] = '{8'h74, 2'd0, 1, 0, 8'h74, 1, 0};
    tv[21] = '{8'hE1, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[22] = '{8'hFE, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[23] = '{8'hEE, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[24] = '{8'hFF, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[25] = '{8'h5A, 2'd0, 1, 0, 8'h5A, 1, 0};
    tv[26] = '{8'hF0, 2'd0, 0, 0, 8'h00, 0, 0};
    tv[27] = '{8'h74, 2'd0, 1, 0, 8'h74, 0, 0};
    tv[28] = '{8'h29, 2'd2, 0, 1, 8'h00, 0, 0};
    tv[29] = '{8'h29, 2'd0, 1, 0, 8'h29, 1, 0};

    tick(5);
    chk("reset key_strobe", key_strobe, 0);
    chk("reset key_pressed", key_pressed, 0);
    chk("reset key_extended", key_extended, 0);
    chk("reset key_code", key_code, 0);
    chk("reset frame_err", frame_err, 0);
    reset = 1'b0;
    tick(5);
    evq.delete();

    for (int i = 0; i < NV; i++) begin
      send_frame(tv[i].b, tv[i].bad, c0);
      tick(FILT + 10);
      check_events($sformatf("v%0d", i), tv[i].exp_s, tv[i].exp_e,
                   tv[i].code, tv[i].pr, tv[i].ex, c0 + FILT + 4);
    end

    // Timeout: start plus four data bits, then idle lines.
    send_bit(1'b0, c);
    for (int i = 0; i < 4; i++) send_bit(1'b1, c0);
    tick(TIMEOUT + 20);
    check_events("timeout", 0, 1, 8'h00, 0, 0, c0 + FILT + 2 + TIMEOUT);
    send_frame(8'h29, 2'd0, c0);
    tick(FILT + 10);
    check_events("after timeout", 1, 0, 8'h29, 1, 0, c0 + FILT + 4);

    // Sub-FILT glitches with data low would start a frame if accepted.
    ps2_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      tick(FILT - 1);
      ps2_clk = 1'b1;
      tick(10);
    end
    ps2_data = 1'b1;
    tick(TIMEOUT + 20);
    chk("glitch no events", evq.size(), 0);
    evq.delete();

    // Reset after bit 5 of a frame.
    b45 = 8'h45;
    send_bit(1'b0, c);
    for (int i = 0; i < 6; i++) send_bit(b45[i], c);
    reset = 1'b1;
    tick(2);
    chk("midreset key_strobe", key_strobe, 0);
    chk("midreset key_pressed", key_pressed, 0);
    chk("midreset key_extended", key_extended, 0);
    chk("midreset key_code", key_code, 0);
    chk("midreset frame_err", frame_err, 0);
    reset = 1'b0;
    tick(TIMEOUT + 20);
    chk("midreset no events", evq.size(), 0);
    evq.delete();
    send_frame(8'h45, 2'd0, c0);
    tick(FILT + 10);
    check_events("after reset", 1, 0, 8'h45, 1, 0, c0 + FILT + 4);

    chk("strobe and err overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
